pipe_stage_skid: RTL

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 95 +++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid-buffered valid/ready pipeline stage.
// Optional stall counter: define PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  if (DATA_W < 1 || DATA_W > 256) begin : g_bad_data_w
    $error("DATA_W out of range");
  end
  if (PERF_W < 8 || PERF_W > 64) begin : g_bad_perf_w
    $error("PERF_W out of range");
  end

  logic [1:0]        state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              accept;
  logic              pop;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign out_data  = main_q;
  assign occupancy = state;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // State and payload registers; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            main_q <= in_data;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (accept && pop) begin
            main_q <= in_data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  // Saturating count of cycles the held payload is refused downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
